// File: rtl/bayer_mosaic.sv
// RGB-to-Bayer encoder: emits one raw sample per accepted pixel (even rows G B, odd rows R G), 1-cycle latency.
// Optional per-frame channel sums are enabled by defining BAYER_MOSAIC_STATS_EN.
module bayer_mosaic #(
    parameter int width  = 320,
    parameter int height = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       newFrame,
    input  logic                       iValid,
    input  logic [7:0]                 iR,
    input  logic [7:0]                 iG,
    input  logic [7:0]                 iB,
    output logic                       oValid,
    output logic [7:0]                 oData,
    output logic                       oDone,
    output logic [$clog2(height)-1:0]  oRow,
    output logic [$clog2(width)-1:0]   oCol
`ifdef BAYER_MOSAIC_STATS_EN
    ,
    output logic [31:0]                oSumR,
    output logic [31:0]                oSumG,
    output logic [31:0]                oSumB,
    output logic                       oStatsValid
`endif
);

    localparam int CW = $clog2(width);
    localparam int RW = $clog2(height);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt, pix_col;
    logic [RW-1:0] row, row_nxt, pix_row;
    logic          accept;
    logic          last;
    logic [7:0]    sample;

    // newFrame forces the position of a same-cycle pixel to (0,0) and overrides any increment.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        pix_col   = newFrame ? '0 : col;
        pix_row   = newFrame ? '0 : row;
        col_nxt   = pix_col;
        row_nxt   = pix_row;
        accept    = iValid && (newFrame || state == ACTIVE);
        last      = (pix_col == CW'(width - 1)) && (pix_row == RW'(height - 1));

        if (newFrame)
            state_nxt = ACTIVE;

        if (accept) begin
            if (last) begin
                state_nxt = DONE;
                col_nxt   = '0;
                row_nxt   = '0;
            end else if (pix_col == CW'(width - 1)) begin
                col_nxt = '0;
                row_nxt = pix_row + 1'b1;
            end else begin
                col_nxt = pix_col + 1'b1;
            end
        end

        unique case ({pix_row[0], pix_col[0]})
            2'b00:   sample = iG;
            2'b01:   sample = iB;
            2'b10:   sample = iR;
            default: sample = iG;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            oValid <= 1'b0;
            oData  <= '0;
            oDone  <= 1'b0;
            oRow   <= '0;
            oCol   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state  <= state_nxt;
            col    <= col_nxt;
            row    <= row_nxt;
            oValid <= accept;
            if (accept) begin
                oData <= sample;
                oRow  <= pix_row;
                oCol  <= pix_col;
            end
            if (newFrame)
                oDone <= 1'b0;
            if (accept && last)
                oDone <= 1'b1;
        end
    end

`ifdef BAYER_MOSAIC_STATS_EN
    // Sums follow the registered output stream, so they settle one cycle after oDone rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oSumR       <= '0;
            oSumG       <= '0;
            oSumB       <= '0;
            oStatsValid <= 1'b0;
        end else if (newFrame) begin
            oSumR       <= '0;
            oSumG       <= '0;
            oSumB       <= '0;
            oStatsValid <= 1'b0;
        end else begin
            oStatsValid <= oDone;
            if (oValid) begin
                unique case ({oRow[0], oCol[0]})
                    2'b01:   oSumB <= oSumB + 32'(oData);
                    2'b10:   oSumR <= oSumR + 32'(oData);
                    default: oSumG <= oSumG + 32'(oData);
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_bayer_mosaic.sv
// Self-checking bench for bayer_mosaic: random frame against a pixel-index reference model plus directed corner cases.
// Checks the stats outputs too when BAYER_MOSAIC_STATS_EN is defined.
module tb_bayer_mosaic;

    localparam int W     = 320;
    localparam int H     = 240;
    localparam int TOTAL = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       newFrame;
    logic       iValid;
    logic [7:0] iR, iG, iB;
    logic       oValid;
    logic [7:0] oData;
    logic       oDone;
    logic [7:0] oRow;
    logic [8:0] oCol;
`ifdef BAYER_MOSAIC_STATS_EN
    logic [31:0] oSumR, oSumG, oSumB;
    logic        oStatsValid;
`endif

    bayer_mosaic #(.width(W), .height(H)) dut (
        .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid),
        .iR(iR), .iG(iG), .iB(iB),
        .oValid(oValid), .oData(oData), .oDone(oDone), .oRow(oRow), .oCol(oCol)
`ifdef BAYER_MOSAIC_STATS_EN
        , .oSumR(oSumR), .oSumG(oSumG), .oSumB(oSumB), .oStatsValid(oStatsValid)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a linear pixel index within the frame, row/col derived by division.
    bit          in_frame = 0;
    int          n = 0;
    logic        e_valid = 0;
    logic [7:0]  e_data = 0;
    int          e_row = 0, e_col = 0;
    logic        e_done = 0;
    logic        e_sv = 0;
    logic [31:0] sum_r = 0, sum_g = 0, sum_b = 0;
    int          valid_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pick(input int r, input int c, input logic [7:0] vr,
                                        input logic [7:0] vg, input logic [7:0] vb);
        if (r % 2 == 0) return (c % 2 == 0) ? vg : vb;
        return (c % 2 == 0) ? vr : vg;
    endfunction

    task automatic model_reset();
        in_frame = 0; n = 0; e_valid = 0; e_data = 0; e_row = 0; e_col = 0;
        e_done = 0; e_sv = 0; sum_r = 0; sum_g = 0; sum_b = 0;
    endtask

    task automatic step(input bit nf, input bit v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        bit acc;
        newFrame = nf; iValid = v; iR = r; iG = g; iB = b;
        @(posedge clk);
        e_sv = nf ? 1'b0 : e_done;
        if (nf) begin
            in_frame = 1; n = 0; e_done = 0; sum_r = 0; sum_g = 0; sum_b = 0;
        end
        acc = v && in_frame;
        e_valid = acc;
        if (acc) begin
            e_row  = n / W;
            e_col  = n % W;
            e_data = pick(e_row, e_col, r, g, b);
            if (e_row % 2 == 1 && e_col % 2 == 0) sum_r += 32'(e_data);
            else if (e_row % 2 == 0 && e_col % 2 == 1) sum_b += 32'(e_data);
            else sum_g += 32'(e_data);
            n++;
            if (n == TOTAL) begin
                in_frame = 0;
                e_done   = 1;
            end
        end
        @(negedge clk);
        check("valid", oValid, e_valid);
        check("data", oData, e_data);
        check("row", oRow, e_row);
        check("col", oCol, e_col);
        check("done", oDone, e_done);
        if (oValid) valid_seen++;
`ifdef BAYER_MOSAIC_STATS_EN
        check("stats_valid", oStatsValid, e_sv);
        if (e_sv) begin
            check("sum_r", oSumR, sum_r);
            check("sum_g", oSumG, sum_g);
            check("sum_b", oSumB, sum_b);
        end
`endif
    endtask

    initial begin
        reset = 1; newFrame = 0; iValid = 0; iR = 0; iG = 0; iB = 0;
        #12;
        check("rst_valid", oValid, 0);
        check("rst_data", oData, 0);
        check("rst_done", oDone, 0);
        check("rst_row", oRow, 0);
        check("rst_col", oCol, 0);
        @(negedge clk);
        reset = 0;

        // Idle state ignores iValid.
        repeat (3) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom));

        // Full random frame with short random row gaps; last pixel green forced to 0xAB.
        valid_seen = 0;
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(0, 1, 8'($urandom),
                     (r == H - 1 && c == W - 1) ? 8'hAB : 8'($urandom), 8'($urandom));
                if (r < H - 1 && c == W - 1)
                    repeat ($urandom_range(0, 2)) step(0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        check("last_data", oData, 8'hAB);
        check("last_row", oRow, H - 1);
        check("last_col", oCol, W - 1);
        check("last_done", oDone, 1);
        check("frame_valid_count", valid_seen, TOTAL);

        // Input after frame completion is ignored.
        repeat (50) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
        check("post_valid", oValid, 0);
        check("post_done", oDone, 1);
`ifdef BAYER_MOSAIC_STATS_EN
        check("post_stats_valid", oStatsValid, 1);
`endif

        // Partial constant frame with 16-cycle row blanking, then a mid-frame restart.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 1000; k++) begin
            step(0, 1, 1, 2, 3);
            check("pattern", oData, ((k / W) % 2 == 0) ? (((k % W) % 2 == 0) ? 2 : 3)
                                                       : (((k % W) % 2 == 0) ? 1 : 2));
            if (k % W == W - 1) repeat (16) step(0, 0, 1, 2, 3);
        end
        step(1, 1, 9, 8, 7);
        check("restart_data", oData, 8);
        check("restart_row", oRow, 0);
        check("restart_col", oCol, 0);
        check("restart_done", oDone, 0);
        for (int c = 1; c < 20; c++) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom));

        // Asynchronous reset between edges, mid-row.
        #2 reset = 1;
        #1;
        check("arst_valid", oValid, 0);
        check("arst_data", oData, 0);
        check("arst_done", oDone, 0);
        check("arst_row", oRow, 0);
        check("arst_col", oCol, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        repeat (10) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
        check("arst_no_valid", oValid, 0);

        // Recovery after a fresh newFrame.
        step(1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (8) step(0, 1, 8'($urandom), 8'($urandom), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
